// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the
// baud divisor helper used by both the transmitter and the receiver.
package uart_pkg;

   localparam int UART_DATA_W    = 8;
   localparam int UART_STOP_BITS = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // Clock cycles per bit, rounded to the nearest integer.
   function automatic int calc_baud_div(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_with_fifo_tx_if.sv
// Host-side bus of the buffered UART transmitter: byte push, FIFO status
// and the serial line with its frame status.
interface uart_with_fifo_tx_if #(
   parameter int FIFO_AW = 4
) ();

   logic                               wr_en;
   logic [uart_pkg::UART_DATA_W-1:0]   din;
   logic                               full;
   logic                               almost_full;
   logic [FIFO_AW:0]                   data_count;
   logic                               overflow;
   logic                               tx_serial_data;
   logic                               tx_busy;
   logic                               tx_done;

   modport master (
      output wr_en, din,
      input  full, almost_full, data_count, overflow,
      input  tx_serial_data, tx_busy, tx_done
   );

   modport slave (
      input  wr_en, din,
      output full, almost_full, data_count, overflow,
      output tx_serial_data, tx_busy, tx_done
   );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with registered occupancy flags. Head data is read
// combinationally so the consumer can load it on the same edge as the pop.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_AW = 4
) (
   input  logic                   clk_in,
   input  logic                   rst,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [UART_DATA_W-1:0] din_i,
   output logic [UART_DATA_W-1:0] dout_o,
   output logic                   full_o,
   output logic                   almost_full_o,
   output logic [FIFO_AW:0]       count_o,
   output logic                   overflow_o
);

   localparam int               DEPTH   = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
   localparam logic [FIFO_AW:0] CNT_ONE = (FIFO_AW + 1)'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

   logic [UART_DATA_W-1:0] mem_q [DEPTH];
   logic [FIFO_AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]       count_q, count_d;
   logic                   full_q, afull_q, ovf_q;
   logic                   wr_ok, rd_ok;

   // Writes qualify against the registered full flag; a push while full is dropped.
   assign wr_ok = push_i & ~full_q;
   assign rd_ok = pop_i & (count_q != '0);

   // Occupancy next state; push and pop together leave it unchanged.
   always_comb begin
      count_d = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and status flags, all registered.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_d;
         full_q  <= (count_d == DEPTH_C);
         afull_q <= (count_d >= DEPTH_C - CNT_ONE);
         ovf_q   <= push_i & full_q;
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk_in) begin
      if (wr_ok) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o        = mem_q[rd_ptr_q];
   assign full_o        = full_q;
   assign almost_full_o = afull_q;
   assign count_o       = count_q;
   assign overflow_o    = ovf_q;

endmodule

// File: rtl/uart_with_fifo_tx.sv
// Buffered 8N1 UART transmitter. Queued bytes are popped by the frame FSM
// and shifted out LSB first; frames chain without an idle gap while the
// FIFO has data. The baud counter restarts with every frame.
module uart_with_fifo_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200,
   parameter int FIFO_AW  = 4
) (
   input  logic             clk_in,
   input  logic             rst,
   uart_with_fifo_tx_if.slave bus
);

   localparam int            BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
   localparam int            CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam int            BW       = $clog2(UART_DATA_W);
   localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_W - 1);
   localparam logic [BW-1:0] BIT_ONE  = BW'(1);

   uart_state_e            state_q, state_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [BW-1:0]          bit_q, bit_d;
   logic [UART_DATA_W-1:0] sh_q, sh_d;
   logic [UART_DATA_W-1:0] fifo_dout;
   logic                   pop, done, line;
   logic                   has_data, baud_last;

   uart_sync_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clk_in        (clk_in),
      .rst           (rst),
      .push_i        (bus.wr_en),
      .pop_i         (pop),
      .din_i         (bus.din),
      .dout_o        (fifo_dout),
      .full_o        (bus.full),
      .almost_full_o (bus.almost_full),
      .count_o       (bus.data_count),
      .overflow_o    (bus.overflow)
   );

   assign has_data  = (bus.data_count != '0);
   assign baud_last = (cnt_q == CNT_LAST);

   // Frame state, baud phase, bit index and shifter.
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
      end
   end

   // Frame sequencing and line drive; STOP reloads directly into START when data waits.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pop     = 1'b0;
      done    = 1'b0;
      line    = 1'b1;
      case (state_q)
         IDLE: begin
            if (has_data) begin
               pop     = 1'b1;
               sh_d    = fifo_dout;
               cnt_d   = '0;
               state_d = START;
            end
         end
         START: begin
            line = 1'b0;
            if (baud_last) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DATA: begin
            line = sh_q[0];
            if (baud_last) begin
               cnt_d = '0;
               sh_d  = {1'b0, sh_q[UART_DATA_W-1:1]};
               if (bit_q == BIT_LAST) state_d = STOP;
               else                   bit_d   = bit_q + BIT_ONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         STOP: begin
            line = 1'b1;
            if (baud_last) begin
               done  = 1'b1;
               cnt_d = '0;
               if (has_data) begin
                  pop     = 1'b1;
                  sh_d    = fifo_dout;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.tx_serial_data = line;
   assign bus.tx_busy        = (state_q != IDLE);
   assign bus.tx_done        = done;

endmodule
